// File: rtl/mmio_ram_pkg.sv
// Shared definitions for the MMIO data memory: PIT register map, CTRL bit
// positions, region-decode encoding and the byte-lane merge helper.
package mmio_ram_pkg;

    localparam int unsigned PIT_OFF_RELOAD = 0;
    localparam int unsigned PIT_OFF_CTRL   = 4;
    localparam int unsigned PIT_OFF_COUNT  = 8;

    localparam int unsigned CTRL_EN_BIT  = 0;
    localparam int unsigned CTRL_PER_BIT = 1;

    typedef enum logic [2:0] {
        REG_RAM,
        REG_PIT_RELOAD,
        REG_PIT_CTRL,
        REG_PIT_COUNT,
        REG_NONE
    } region_e;

    // Lanes with wen set come from new_word, the rest keep old_word.
    function automatic logic [31:0] lane_merge(input logic [31:0] old_word,
                                               input logic [31:0] new_word,
                                               input logic [3:0]  wen);
        logic [31:0] res;
        for (int i = 0; i < 4; i++) begin
            res[8*i +: 8] = wen[i] ? new_word[8*i +: 8] : old_word[8*i +: 8];
        end
        return res;
    endfunction

endpackage

// File: rtl/pit_timer.sv
// Programmable interval timer: RELOAD/CTRL/COUNT registers, IDLE/RUN state
// machine and a sticky pending flag. Runs every clock, independent of clk_en.
module pit_timer
    import mmio_ram_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic [3:0]  reload_we,
    input  logic [3:0]  ctrl_we,
    input  logic [31:0] wdata,
    input  logic        irq_ack,
    output logic [31:0] reload_q,
    output logic [31:0] ctrl_q,
    output logic [31:0] count_q,
    output logic        timer_irq
);

    typedef enum logic {PIT_IDLE, PIT_RUN} pit_state_e;

    pit_state_e  state;
    logic        periodic;
    logic [31:0] reload_nxt;
    logic        ctrl_hit;
    logic        en_wr;
    logic        per_nxt;
    logic        expire;
    logic        unused_ctrl_lanes;

    // CTRL only has bits in lane 0; the upper lanes are write-ignored.
    assign unused_ctrl_lanes = ^ctrl_we[3:1];

    always_comb begin
        reload_nxt = lane_merge(reload_q, wdata, reload_we);
        ctrl_hit   = ctrl_we[0];
        en_wr      = wdata[CTRL_EN_BIT];
        per_nxt    = ctrl_hit ? wdata[CTRL_PER_BIT] : periodic;
        expire     = (state == PIT_RUN) && (count_q == 32'd0) && !(ctrl_hit && !en_wr);
    end

    always_comb begin
        ctrl_q               = '0;
        ctrl_q[CTRL_EN_BIT]  = (state == PIT_RUN);
        ctrl_q[CTRL_PER_BIT] = periodic;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= PIT_IDLE;
            periodic  <= 1'b0;
            reload_q  <= '0;
            count_q   <= '0;
            timer_irq <= 1'b0;
        end else begin
            reload_q <= reload_nxt;
            periodic <= per_nxt;

            // An expiry on the same edge as an acknowledge keeps the flag set.
            if (expire) begin
                timer_irq <= 1'b1;
            end else if (irq_ack) begin
                timer_irq <= 1'b0;
            end

            case (state)
                PIT_IDLE: begin
                    if (ctrl_hit && en_wr) begin
                        count_q <= reload_nxt;
                        state   <= PIT_RUN;
                    end
                end
                PIT_RUN: begin
                    if (ctrl_hit && !en_wr) begin
                        state <= PIT_IDLE;
                    end else if (count_q != 32'd0) begin
                        count_q <= count_q - 32'd1;
                    end else if (per_nxt) begin
                        count_q <= reload_nxt;
                    end else begin
                        state <= PIT_IDLE;
                    end
                end
                default: state <= PIT_IDLE;
            endcase
        end
    end

endmodule

// File: rtl/mmio_ram.sv
// Byte-addressed data RAM with NREAD two-stage read ports, one byte-lane write
// port, same-cycle write forwarding and an integrated PIT in the MMIO space.
module mmio_ram
    import mmio_ram_pkg::*;
#(
    parameter int unsigned        ADDR_W    = 18,
    parameter int unsigned        RAM_WORDS = 32768,
    parameter int unsigned        NREAD     = 2,
    parameter logic [ADDR_W-1:0]  RAM_TOP   = ADDR_W'(32'h20000),
    parameter logic [ADDR_W-1:0]  PIT_BASE  = ADDR_W'(32'h20004)
)(
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    clk_en,
    input  logic [NREAD*ADDR_W-1:0] raddr,
    output logic [NREAD*32-1:0]     rdata,
    input  logic [3:0]              wen,
    input  logic [ADDR_W-1:0]       waddr,
    input  logic [31:0]             wdata,
    input  logic                    irq_ack,
    output logic                    timer_irq
);

    localparam int unsigned       IDX_W     = $clog2(RAM_WORDS);
    localparam logic [ADDR_W-1:0] A_RELOAD  = PIT_BASE + ADDR_W'(PIT_OFF_RELOAD);
    localparam logic [ADDR_W-1:0] A_CTRL    = PIT_BASE + ADDR_W'(PIT_OFF_CTRL);
    localparam logic [ADDR_W-1:0] A_COUNT   = PIT_BASE + ADDR_W'(PIT_OFF_COUNT);
    localparam logic [31:0]       CTRL_MASK = (32'd1 << CTRL_EN_BIT) | (32'd1 << CTRL_PER_BIT);

    // Full-address decode; the byte offset inside a word never selects a region.
    function automatic region_e decode(input logic [ADDR_W-1:0] a);
        logic [ADDR_W-1:0] wa;
        wa = {a[ADDR_W-1:2], 2'b00};
        if (a < RAM_TOP)    return REG_RAM;
        if (wa == A_RELOAD) return REG_PIT_RELOAD;
        if (wa == A_CTRL)   return REG_PIT_CTRL;
        if (wa == A_COUNT)  return REG_PIT_COUNT;
        return REG_NONE;
    endfunction

    logic [31:0]      mem [RAM_WORDS];
    region_e          w_region;
    logic             wr_act;
    logic             ram_we;
    logic [IDX_W-1:0] w_idx;
    logic [3:0]       reload_we;
    logic [3:0]       ctrl_we;
    logic [31:0]      pit_reload;
    logic [31:0]      pit_ctrl;
    logic [31:0]      pit_count;
    logic [31:0]      pit_reload_fwd;
    logic [31:0]      pit_ctrl_fwd;

    always_comb begin
        w_region  = decode(waddr);
        wr_act    = clk_en && (wen != 4'h0);
        ram_we    = wr_act && (w_region == REG_RAM);
        w_idx     = waddr[IDX_W+1:2];
        reload_we = (wr_act && (w_region == REG_PIT_RELOAD)) ? wen : 4'h0;
        ctrl_we   = (wr_act && (w_region == REG_PIT_CTRL))   ? wen : 4'h0;
    end

    always_ff @(posedge clk) begin
        if (ram_we) begin
            for (int i = 0; i < 4; i++) begin
                if (wen[i]) begin
                    mem[w_idx][8*i +: 8] <= wdata[8*i +: 8];
                end
            end
        end
    end

    pit_timer u_pit (
        .clk       (clk),
        .rst_n     (rst_n),
        .reload_we (reload_we),
        .ctrl_we   (ctrl_we),
        .wdata     (wdata),
        .irq_ack   (irq_ack),
        .reload_q  (pit_reload),
        .ctrl_q    (pit_ctrl),
        .count_q   (pit_count),
        .timer_irq (timer_irq)
    );

    // PIT registers as they will be after this cycle's write.
    always_comb begin
        pit_reload_fwd = lane_merge(pit_reload, wdata, reload_we);
        pit_ctrl_fwd   = lane_merge(pit_ctrl, wdata, ctrl_we) & CTRL_MASK;
    end

    for (genvar p = 0; p < NREAD; p++) begin : g_rd
        logic [ADDR_W-1:0] addr_p0;
        logic [IDX_W-1:0]  idx_p0;
        logic [31:0]       ram_p0;
        logic [31:0]       pit_p0;
        logic [ADDR_W-1:0] addr_p1;
        logic [31:0]       ram_p1;
        logic [31:0]       pit_p1;
        logic [31:0]       mux_p1;
        logic [31:0]       rdata_p2;

        always_comb begin
            addr_p0 = raddr[p*ADDR_W +: ADDR_W];
            idx_p0  = addr_p0[IDX_W+1:2];
            ram_p0  = (ram_we && (idx_p0 == w_idx)) ? lane_merge(mem[idx_p0], wdata, wen)
                                                    : mem[idx_p0];
            case (decode(addr_p0))
                REG_PIT_RELOAD: pit_p0 = pit_reload_fwd;
                REG_PIT_CTRL:   pit_p0 = pit_ctrl_fwd;
                REG_PIT_COUNT:  pit_p0 = pit_count;
                default:        pit_p0 = '0;
            endcase
        end

        // Stage 1: address and candidate words, forwarding already applied
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                addr_p1 <= '0;
                ram_p1  <= '0;
                pit_p1  <= '0;
            end else if (clk_en) begin
                addr_p1 <= addr_p0;
                ram_p1  <= ram_p0;
                pit_p1  <= pit_p0;
            end
        end

        always_comb begin
            case (decode(addr_p1))
                REG_RAM:  mux_p1 = ram_p1;
                REG_NONE: mux_p1 = '0;
                default:  mux_p1 = pit_p1;
            endcase
        end

        // Stage 2: registered, region-selected read data
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                rdata_p2 <= '0;
            end else if (clk_en) begin
                rdata_p2 <= mux_p1;
            end
        end

        assign rdata[p*32 +: 32] = rdata_p2;
    end

endmodule

// File: tb/tb_mmio_ram.sv
// Scoreboard bench for mmio_ram: read expectations are queued at issue and
// compared when due; PIT and reset behaviour are checked against fixed timelines.
module tb_mmio_ram;

    localparam int AW = 18;

    logic            clk = 1'b0;
    logic            rst_n;
    logic            clk_en;
    logic [2*AW-1:0] raddr;
    logic [63:0]     rdata;
    logic [3:0]      wen;
    logic [AW-1:0]   waddr;
    logic [31:0]     wdata;
    logic            irq_ack;
    logic            timer_irq;

    always #5 clk = ~clk;

    mmio_ram dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .clk_en    (clk_en),
        .raddr     (raddr),
        .rdata     (rdata),
        .wen       (wen),
        .waddr     (waddr),
        .wdata     (wdata),
        .irq_ack   (irq_ack),
        .timer_irq (timer_irq)
    );

    typedef struct {
        int          due;
        int          port;
        logic [31:0] exp;
        string       tag;
    } exp_t;

    exp_t          sb[$];
    logic [31:0]   model [int];
    int            n_chk  = 0;
    int            n_pass = 0;
    int            en_cnt = 0;
    logic [AW-1:0] ra [2];
    logic          rd [2];
    logic          ov [2];
    logic [31:0]   xp [2];
    string         rtag [2];
    logic [31:0]   last_exp [2];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, got, exp);
    endtask

    function automatic logic [31:0] merge(input logic [31:0] o, input logic [31:0] n,
                                          input logic [3:0] m);
        logic [31:0] r;
        r = o;
        for (int i = 0; i < 4; i++) if (m[i]) r[8*i +: 8] = n[8*i +: 8];
        return r;
    endfunction

    function automatic logic [31:0] mget(input logic [AW-1:0] a);
        int k;
        k = int'(a[16:2]);
        return model.exists(k) ? model[k] : 32'h0;
    endfunction

    task automatic tick();
        logic wr_ram;
        raddr  = {ra[1], ra[0]};
        wr_ram = clk_en && (wen != 4'h0) && (waddr < 18'h20000);
        if (clk_en) begin
            for (int p = 0; p < 2; p++) begin
                if (rd[p]) begin
                    exp_t e;
                    e.due  = en_cnt + 2;
                    e.port = p;
                    e.tag  = rtag[p];
                    if (ov[p]) e.exp = xp[p];
                    else begin
                        e.exp = mget(ra[p]);
                        if (wr_ram && (ra[p][AW-1:2] == waddr[AW-1:2]))
                            e.exp = merge(e.exp, wdata, wen);
                    end
                    sb.push_back(e);
                end
            end
        end
        @(posedge clk);
        if (wr_ram) model[int'(waddr[16:2])] = merge(mget(waddr), wdata, wen);
        if (clk_en) en_cnt++;
        #1;
        while (sb.size() > 0 && sb[0].due == en_cnt) begin
            exp_t e;
            e = sb.pop_front();
            check(e.tag, rdata[e.port*32 +: 32], e.exp);
            last_exp[e.port] = e.exp;
        end
    endtask

    task automatic idle_inputs();
        wen = 4'h0; irq_ack = 1'b0;
        for (int p = 0; p < 2; p++) begin
            rd[p] = 1'b0; ov[p] = 1'b0; ra[p] = 18'h2FFF0;
        end
    endtask

    task automatic wr(input logic [AW-1:0] a, input logic [31:0] d, input logic [3:0] m);
        waddr = a; wdata = d; wen = m;
        tick();
        wen = 4'h0;
    endtask

    task automatic rd_ram(input int p, input logic [AW-1:0] a, input string t);
        ra[p] = a; rd[p] = 1'b1; ov[p] = 1'b0; rtag[p] = t;
    endtask

    task automatic rd_exp(input int p, input logic [AW-1:0] a, input logic [31:0] x, input string t);
        ra[p] = a; rd[p] = 1'b1; ov[p] = 1'b1; xp[p] = x; rtag[p] = t;
    endtask

    task automatic settle();
        idle_inputs();
        tick(); tick();
    endtask

    task automatic chk_irq(input string t, input logic e);
        check(t, {31'b0, timer_irq}, {31'b0, e});
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        rst_n = 1'b0; clk_en = 1'b0; waddr = '0; wdata = '0;
        idle_inputs();
        raddr = {ra[1], ra[0]};
        repeat (2) @(posedge clk);
        #1;
        check("rst_rdata0", rdata[31:0], 32'h0);
        check("rst_rdata1", rdata[63:32], 32'h0);
        chk_irq("rst_irq", 1'b0);
        rst_n = 1'b1; clk_en = 1'b1;

        // Write then read, both ports
        wr(18'h00100, 32'hDEADBEEF, 4'hF);
        wr(18'h00300, 32'hCAFEF00D, 4'hF);
        wr(18'h0FFF0, 32'h5A5AA5A5, 4'hF);
        wr(18'h00200, 32'h11223344, 4'hF);
        rd_ram(0, 18'h00100, "wr_rd_p0"); rd_ram(1, 18'h00100, "wr_rd_p1");
        tick(); settle();

        // Same-cycle forwarding
        waddr = 18'h00200; wdata = 32'hAABBCCDD; wen = 4'b0101;
        rd_ram(0, 18'h00200, "fwd_p0"); rd_ram(1, 18'h00200, "fwd_p1");
        tick(); settle();
        check("fwd_value", last_exp[0], 32'h11BB33DD);
        waddr = 18'h00100; wdata = 32'h77000000; wen = 4'b1000;
        rd_ram(0, 18'h00300, "fwd_other"); rd_ram(1, 18'h00100, "fwd_hi");
        tick(); settle();
        rd_ram(0, 18'h00200, "fwd_stuck"); rd_ram(1, 18'h00100, "fwd_hi_stuck");
        tick(); settle();

        // Stall holds both stages and rdata
        rd_ram(0, 18'h00100, "pre_stall0"); rd_ram(1, 18'h00300, "pre_stall1");
        tick();
        rd_ram(0, 18'h00300, "stall_res0"); rd_ram(1, 18'h00200, "stall_res1");
        tick();
        idle_inputs();
        clk_en = 1'b0;
        ra[0] = 18'h00200; ra[1] = 18'h00100;
        for (int i = 0; i < 5; i++) begin
            tick();
            check($sformatf("stall_hold0_%0d", i), rdata[31:0], last_exp[0]);
            check($sformatf("stall_hold1_%0d", i), rdata[63:32], last_exp[1]);
        end
        clk_en = 1'b1;
        tick();
        settle();

        // PIT one-shot
        wr(18'h20004, 32'd3, 4'hF);
        wr(18'h20008, 32'd1, 4'hF);
        for (int i = 0; i < 4; i++) begin
            rd_exp(0, 18'h2000C, 32'(3 - i), $sformatf("count_%0d", i));
            tick();
            chk_irq($sformatf("irq_oneshot_%0d", i), i == 3);
        end
        rd_exp(0, 18'h20008, 32'd0, "ctrl_after_oneshot");
        rd_exp(1, 18'h20004, 32'd3, "reload_read");
        tick(); settle();
        chk_irq("irq_sticky", 1'b1);

        // PIT periodic, acknowledge colliding with expiry
        irq_ack = 1'b1; tick(); irq_ack = 1'b0;
        chk_irq("ack_clear", 1'b0);
        wr(18'h20004, 32'd0, 4'hF);
        wr(18'h20008, 32'd3, 4'hF);
        tick();
        chk_irq("per_expire", 1'b1);
        irq_ack = 1'b1; tick(); irq_ack = 1'b0;
        chk_irq("ack_collide", 1'b1);
        tick();
        chk_irq("per_again", 1'b1);
        waddr = 18'h20004; wdata = 32'd4; wen = 4'hF;
        rd_exp(0, 18'h20004, 32'd4, "reload_fwd");
        tick(); idle_inputs();
        wr(18'h20008, 32'd0, 4'hF);
        wr(18'h20008, 32'd3, 4'hF);
        for (int i = 0; i < 4; i++) begin
            irq_ack = (i == 0);
            if (i == 1) rd_exp(1, 18'h20008, 32'd3, "ctrl_periodic");
            tick();
            idle_inputs();
            chk_irq($sformatf("ack_gap_%0d", i), 1'b0);
        end
        tick();
        chk_irq("gap_reexpire", 1'b1);
        settle();

        // Unmapped space
        rd_exp(0, 18'h2FFF0, 32'h0, "unmap_rd"); rd_exp(1, 18'h20000, 32'h0, "gap_rd");
        tick(); idle_inputs();
        wr(18'h2FFF0, 32'hFFFFFFFF, 4'hF);
        wr(18'h20010, 32'hFFFFFFFF, 4'hF);
        rd_exp(0, 18'h2FFF0, 32'h0, "unmap_after"); rd_ram(1, 18'h0FFF0, "alias_word");
        tick();
        rd_ram(0, 18'h00100, "ram_intact"); rd_exp(1, 18'h20004, 32'd4, "reload_intact");
        tick(); settle();

        // Asynchronous reset mid-count
        wr(18'h20008, 32'd0, 4'hF);
        wr(18'h20004, 32'd100, 4'hF);
        wr(18'h20008, 32'd1, 4'hF);
        rd_ram(0, 18'h00100, "pre_rst0"); rd_ram(1, 18'h00300, "pre_rst1");
        tick(); tick(); tick();
        #2 rst_n = 1'b0;
        #1;
        check("arst_rdata0", rdata[31:0], 32'h0);
        check("arst_rdata1", rdata[63:32], 32'h0);
        chk_irq("arst_irq", 1'b0);
        sb.delete();
        @(negedge clk);
        rst_n = 1'b1;
        idle_inputs();
        rd_exp(0, 18'h2000C, 32'h0, "count_after_rst");
        rd_exp(1, 18'h20008, 32'h0, "ctrl_after_rst");
        tick();
        check("stage_rst0", rdata[31:0], 32'h0);
        rd_exp(0, 18'h20004, 32'h0, "reload_after_rst");
        rd[1] = 1'b0;
        tick(); settle();
        chk_irq("irq_after_rst", 1'b0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
